shape_vertices: RTL and testbench

//  Local->screen counterpart of the per-pixel shape rasteriser: from one piece's pose (type, size,
//  sin/cos, integer screen origin) computes the screen-space corner vertices in order, streams them

---
 rtl/tangram_pkg.sv | 53 +++++
 rtl/shape_vertices_fixed_mul.sv | 19 +
 rtl/shape_vertices.sv | 191 +++++++++++++++++++
 tb/tb_shape_vertices.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tangram_pkg.sv
// Shared tangram definitions: shape enum, FSM states, vertex tables.
// Fixed-point format: FLOAT_BITS signed, FLOAT_DCM_BITS fractional.
package tangram_pkg;

  localparam int INT_BITS       = 16;
  localparam int FLOAT_BITS     = 16;
  localparam int FLOAT_DCM_BITS = 8;

  typedef enum logic [1:0] {
    SHAPE_TRIANGLE      = 2'd0,
    SHAPE_SQUARE        = 2'd1,
    SHAPE_PARALLELOGRAM = 2'd2
  } shape_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MUL,
    ST_EMIT,
    ST_DONE
  } state_t;

  function automatic logic [2:0] vertex_count(input shape_t ty);
    logic [2:0] n;
    n = 3'd4;
    if (ty == SHAPE_TRIANGLE) n = 3'd3;
    return n;
  endfunction

  function automatic void local_vertex(
    input  shape_t     ty,
    input  logic [1:0] idx,
    input  int         s,
    output int         xl,
    output int         yl
  );
    xl = 0;
    yl = 0;
    unique case (idx)
      2'd1: xl = s;
      2'd2: begin
        yl = s;
        if (ty == SHAPE_SQUARE) xl = s;
      end
      2'd3: begin
        yl = s;
        if (ty == SHAPE_PARALLELOGRAM) xl = -s;
      end
      default: ;
    endcase
  endfunction

endpackage

// File: rtl/shape_vertices_fixed_mul.sv
// Registered signed multiplier shared by all four
// rotation products of a vertex.
module fixed_mul #(
  parameter int AW = 16,
  parameter int BW = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [AW-1:0]     a,
  input  logic signed [BW-1:0]     b,
  output logic signed [AW+BW-1:0]  p
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p <= '0;
    else        p <= a * b;
  end

endmodule

// File: rtl/shape_vertices.sv
// Local->screen vertex generator for one tangram piece:
// rotates shape corners, streams them, reports bbox.
module shape_vertices
  import tangram_pkg::*;
#(
  parameter int IW = INT_BITS,
  parameter int FW = FLOAT_BITS,
  parameter int DW = FLOAT_DCM_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [IW-1:0]        ty,
  input  logic [IW-1:0]        size,
  input  logic signed [FW-1:0] sin,
  input  logic signed [FW-1:0] cos,
  input  logic signed [IW-1:0] px,
  input  logic signed [IW-1:0] py,
  output logic                 busy,
  output logic                 v_valid,
  input  logic                 v_ready,
  output logic [1:0]           v_idx,
  output logic                 v_last,
  output logic signed [IW-1:0] vx,
  output logic signed [IW-1:0] vy,
  output logic                 done,
  output logic signed [IW-1:0] bb_x0,
  output logic signed [IW-1:0] bb_y0,
  output logic signed [IW-1:0] bb_x1,
  output logic signed [IW-1:0] bb_y1
);

  localparam int PW = IW + FW;

  state_t state, nxt;

  logic [1:0]           k;
  logic [1:0]           idx;
  shape_t               ty_r;
  logic                 ty_ok;
  logic [IW-1:0]        size_r;
  logic signed [FW-1:0] sin_r, cos_r;
  logic signed [IW-1:0] px_r, py_r;
  logic signed [PW-1:0] acc_x, acc_y;
  logic signed [IW-1:0] vx_r, vy_r;
  logic signed [IW-1:0] bx0, by0, bx1, by1;

  logic                 last_v;
  logic [1:0]           k_n, idx_n;
  int                   xl_i, yl_i;
  logic signed [IW-1:0] mul_a;
  logic signed [FW-1:0] mul_b;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] sum_y;
  logic signed [IW-1:0] nx, ny;

  assign last_v = ({1'b0, idx} == vertex_count(ty_r) - 3'd1);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  // FSM: next state
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: if (start) nxt = ST_LOAD;
      ST_LOAD: nxt = ty_ok ? ST_MUL : ST_DONE;
      ST_MUL:  if (k == 2'd3) nxt = ST_EMIT;
      ST_EMIT: if (v_ready) nxt = last_v ? ST_DONE : ST_MUL;
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy    = (state != ST_IDLE);
    v_valid = (state == ST_EMIT);
    v_last  = (state == ST_EMIT) && last_v;
    done    = (state == ST_DONE);
    v_idx   = idx;
    vx      = vx_r;
    vy      = vy_r;
    bb_x0   = bx0;
    bb_y0   = by0;
    bb_x1   = bx1;
    bb_y1   = by1;
  end

  // Operands are issued one cycle ahead so product k
  // is already registered during MUL step k.
  always_comb begin
    k_n   = 2'd0;
    idx_n = idx;
    if (state == ST_MUL)  k_n   = k + 2'd1;
    if (state == ST_EMIT) idx_n = idx + 2'd1;
    if (state == ST_LOAD) idx_n = 2'd0;
    local_vertex(ty_r, idx_n, int'(size_r), xl_i, yl_i);
    mul_a = k_n[0] ? IW'(yl_i) : IW'(xl_i);
    unique case (1'b1)
      (k_n == 2'd0), (k_n == 2'd3): mul_b = cos_r;
      default:                      mul_b = sin_r;
    endcase
  end

  fixed_mul #(
    .AW(IW),
    .BW(FW)
  ) u_mul (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (mul_a),
    .b    (mul_b),
    .p    (prod)
  );

  assign sum_y = acc_y + prod;
  assign nx    = px_r + IW'(acc_x >>> DW);
  assign ny    = py_r + IW'(sum_y >>> DW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k      <= '0;
      idx    <= '0;
      ty_r   <= SHAPE_TRIANGLE;
      ty_ok  <= 1'b0;
      size_r <= '0;
      sin_r  <= '0;
      cos_r  <= '0;
      px_r   <= '0;
      py_r   <= '0;
      acc_x  <= '0;
      acc_y  <= '0;
      vx_r   <= '0;
      vy_r   <= '0;
      bx0    <= '0;
      by0    <= '0;
      bx1    <= '0;
      by1    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (start) begin
          ty_r   <= shape_t'(ty[1:0]);
          ty_ok  <= (ty < IW'(3));
          size_r <= size;
          sin_r  <= sin;
          cos_r  <= cos;
          px_r   <= px;
          py_r   <= py;
          idx    <= '0;
          k      <= '0;
        end
        ST_LOAD: if (!ty_ok) begin
          bx0 <= px_r;
          by0 <= py_r;
          bx1 <= px_r;
          by1 <= py_r;
        end
        ST_MUL: begin
          k <= k + 2'd1;
          unique case (k)
            2'd0: acc_x <= prod;
            2'd1: acc_x <= acc_x - prod;
            2'd2: acc_y <= prod;
            default: begin
              vx_r <= nx;
              vy_r <= ny;
              if (idx == 2'd0) begin
                bx0 <= nx;
                by0 <= ny;
                bx1 <= nx;
                by1 <= ny;
              end else begin
                if (nx < bx0) bx0 <= nx;
                if (ny < by0) by0 <= ny;
                if (nx > bx1) bx1 <= nx;
                if (ny > by1) by1 <= ny;
              end
            end
          endcase
        end
        ST_EMIT: if (v_ready && !last_v) idx <= idx + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shape_vertices.sv
// Randomised self-checking bench for shape_vertices
// against an arithmetic vertex/bbox reference.
module tb_shape_vertices;

  localparam int IW = 16;
  localparam int FW = 16;
  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [IW-1:0]        ty;
  logic [IW-1:0]        size;
  logic signed [FW-1:0] sin;
  logic signed [FW-1:0] cos;
  logic signed [IW-1:0] px;
  logic signed [IW-1:0] py;
  logic                 busy;
  logic                 v_valid;
  logic                 v_ready;
  logic [1:0]           v_idx;
  logic                 v_last;
  logic signed [IW-1:0] vx;
  logic signed [IW-1:0] vy;
  logic                 done;
  logic signed [IW-1:0] bb_x0;
  logic signed [IW-1:0] bb_y0;
  logic signed [IW-1:0] bb_x1;
  logic signed [IW-1:0] bb_y1;

  shape_vertices #(
    .IW(IW),
    .FW(FW),
    .DW(DW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .ty     (ty),
    .size   (size),
    .sin    (sin),
    .cos    (cos),
    .px     (px),
    .py     (py),
    .busy   (busy),
    .v_valid(v_valid),
    .v_ready(v_ready),
    .v_idx  (v_idx),
    .v_last (v_last),
    .vx     (vx),
    .vy     (vy),
    .done   (done),
    .bb_x0  (bb_x0),
    .bb_y0  (bb_y0),
    .bb_x1  (bb_x1),
    .bb_y1  (bb_y1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference: corner tables from the shape definitions,
  // rotation in 64-bit integers, floor shift, IW wrap.
  function automatic void ref_vtx(
    input int ty_a, input int i, input int s,
    input int sn, input int cs, input int ox, input int oy,
    output int x, output int y);
    int lx[4];
    int ly[4];
    longint bx, by;
    logic signed [IW-1:0] tx, tyy;
    case (ty_a)
      0: begin lx = '{0, s, 0, 0}; ly = '{0, 0, s, 0}; end
      1: begin lx = '{0, s, s, 0}; ly = '{0, 0, s, s}; end
      default: begin lx = '{0, s, 0, -s}; ly = '{0, 0, s, s}; end
    endcase
    bx = longint'(lx[i]) * cs - longint'(ly[i]) * sn;
    by = longint'(lx[i]) * sn + longint'(ly[i]) * cs;
    tx  = IW'(longint'(ox) + (bx >>> DW));
    tyy = IW'(longint'(oy) + (by >>> DW));
    x = int'(tx);
    y = int'(tyy);
  endfunction

  task automatic rand_pose();
    ty   = IW'($urandom);
    size = IW'($urandom);
    sin  = FW'($urandom);
    cos  = FW'($urandom);
    px   = IW'($urandom);
    py   = IW'($urandom);
  endtask

  // Caller is positioned 1 time unit after a rising edge.
  task automatic run(input int ty_a, input int s, input int sn,
                     input int cs, input int ox, input int oy,
                     input int max_stall, input bit noisy,
                     input bit done_start);
    int n, x, y, r, cnt;
    int ex0, ey0, ex1, ey1;
    logic signed [IW-1:0] hx, hy;
    logic [1:0] hi;
    cnt = (ty_a == 0) ? 3 : ((ty_a == 1 || ty_a == 2) ? 4 : 0);
    ex0 = 0; ey0 = 0; ex1 = 0; ey1 = 0;
    start = 1'b1;
    ty = IW'(ty_a); size = IW'(s);
    sin = FW'(sn); cos = FW'(cs);
    px = IW'(ox); py = IW'(oy);
    v_ready = (max_stall == 0);
    @(posedge clk); #1;
    start = noisy;
    if (noisy) rand_pose();
    if (cnt == 0) begin
      chk("ill_load_valid", v_valid, 0);
      @(posedge clk); #1;
      start = 1'b0;
      chk("ill_done", done, 1);
      chk("ill_valid", v_valid, 0);
      chk("ill_bbx0", bb_x0, ox);
      chk("ill_bby0", bb_y0, oy);
      chk("ill_bbx1", bb_x1, ox);
      chk("ill_bby1", bb_y1, oy);
    end else begin
      for (int i = 0; i < cnt; i++) begin
        n = 0;
        while (!v_valid && n < 20) begin
          @(posedge clk); #1;
          n++;
          if (noisy) start = 1'($urandom_range(0, 1));
        end
        chk("latency", n, (i == 0) ? 5 : 4);
        ref_vtx(ty_a, i, s, sn, cs, ox, oy, x, y);
        if (i == 0) begin
          ex0 = x; ey0 = y; ex1 = x; ey1 = y;
        end else begin
          if (x < ex0) ex0 = x;
          if (y < ey0) ey0 = y;
          if (x > ex1) ex1 = x;
          if (y > ey1) ey1 = y;
        end
        chk("v_idx", v_idx, i);
        chk("v_last", v_last, (i == cnt - 1) ? 1 : 0);
        chk("vx", vx, x);
        chk("vy", vy, y);
        r = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
        if (r > 0) v_ready = 1'b0;
        hx = vx; hy = vy; hi = v_idx;
        repeat (r) begin
          @(posedge clk); #1;
          chk("hold_valid", v_valid, 1);
          chk("hold_vx", vx, x);
          chk("hold_vy", vy, y);
          chk("hold_idx", v_idx, i);
          if (noisy) start = 1'($urandom_range(0, 1));
        end
        v_ready = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
      end
      chk("done", done, 1);
      chk("bb_x0", bb_x0, ex0);
      chk("bb_y0", bb_y0, ey0);
      chk("bb_x1", bb_x1, ex1);
      chk("bb_y1", bb_y1, ey1);
    end
    if (done_start) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;
    chk("stay_idle", busy, 0);
    chk("stay_novalid", v_valid, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", busy, 0);
    chk("rst_valid", v_valid, 0);
    chk("rst_last", v_last, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", v_idx, 0);
    chk("rst_vx", vx, 0);
    chk("rst_vy", vy, 0);
    chk("rst_bbx0", bb_x0, 0);
    chk("rst_bby0", bb_y0, 0);
    chk("rst_bbx1", bb_x1, 0);
    chk("rst_bby1", bb_y1, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; v_ready = 1'b0;
    ty = '0; size = '0; sin = '0; cos = '0; px = '0; py = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(1, 10, 0, 256, 100, 50, 0, 0, 0);
    run(0, 8, 256, 0, 20, 20, 0, 0, 1);
    run(2, 4, 0, 256, 0, 0, 0, 0, 0);
    run(2, 4, 0, 128, 0, 0, 0, 0, 0);
    run(2, 3, 0, 128, 0, 0, 0, 0, 0);
    run(1, 0, 77, -100, -5, 9, 0, 0, 0);
    run(3, 5, 0, 256, 33, -7, 0, 0, 0);
    run(0, 6, 181, 181, -40, 12, 0, 0, 0);
    run(7, 5, 0, 256, -300, 400, 0, 1, 0);
    run(0, 255, -200, 120, 1000, -1000, 3, 0, 0);

    for (int t = 0; t < 30; t++) begin
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 200)),
          int'($urandom_range(0, 512)) - 256,
          int'($urandom_range(0, 512)) - 256,
          int'($urandom_range(0, 2000)) - 1000,
          int'($urandom_range(0, 2000)) - 1000,
          7, 1, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset while vertex 1 is being offered.
    start = 1'b1; ty = 16'd1; size = 16'd10;
    sin = '0; cos = 16'sd256; px = 16'sd5; py = 16'sd6;
    v_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!v_valid && n < 20) begin @(posedge clk); #1; n++; end
    v_ready = 1'b1;
    @(posedge clk); #1;
    v_ready = 1'b0;
    n = 0;
    while (!v_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("pre_rst_idx", v_idx, 1);
    chk("pre_rst_valid", v_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(1, 10, 0, 256, 5, 6, 2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
